// File: rtl/echo_pkg.sv
// Shared definitions for the echo queue: rule bit indices and the message layout.
package echo_pkg;

  localparam int RULE_DELAY   = 0;
  localparam int RULE_RESPOND = 1;
  localparam int RULE_COUNT   = 2;

  localparam int METH_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [METH_W_DEF-1:0] meth;
    logic [DATA_W_DEF-1:0] v;
  } echo_msg_t;

endpackage

// File: rtl/echo_fifo.sv
// Circular buffer holding queued messages. The head entry is presented
// combinationally and is captured by the consumer's output register.
module echo_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/echo_queue.sv
// Queued echo block: say enqueues, delay_rule loads the output stage,
// respond_rule delivers it through the heard handshake.
module echo_queue
  import echo_pkg::*;
#(
  parameter int METH_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       say__ENA,
  input  logic [METH_W-1:0]          say_meth,
  input  logic [DATA_W-1:0]          say_v,
  output logic                       say__RDY,
  output logic                       indication_heard__ENA,
  output logic [METH_W-1:0]          indication_heard_meth,
  output logic [DATA_W-1:0]          indication_heard_v,
  input  logic                       indication_heard__RDY,
  input  logic [RULE_COUNT-1:0]      rule_enable,
  output logic [RULE_COUNT-1:0]      rule_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           heard_count
);

  localparam int W = METH_W + DATA_W;

  logic              full, empty, out_valid;
  logic [W-1:0]      head;
  logic [METH_W-1:0] out_meth;
  logic [DATA_W-1:0] out_v;
  logic              say_fire, delay_fire, respond_fire;

  assign say__RDY                 = !full;
  assign rule_ready[RULE_DELAY]   = !empty && !out_valid;
  assign rule_ready[RULE_RESPOND] = out_valid && indication_heard__RDY;

  assign say_fire     = say__ENA && say__RDY;
  assign delay_fire   = rule_enable[RULE_DELAY] && rule_ready[RULE_DELAY];
  // Qualified by nRST so a message being flushed is never reported as delivered.
  assign respond_fire = rule_enable[RULE_RESPOND] && rule_ready[RULE_RESPOND] && nRST;

  assign indication_heard__ENA  = respond_fire;
  assign indication_heard_meth  = out_meth;
  assign indication_heard_v     = out_v;

  echo_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .wr_en   (say_fire),
    .wr_data ({say_meth, say_v}),
    .rd_en   (delay_fire),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (occupancy)
  );

  // delay and respond are mutually exclusive through out_valid.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid   <= 1'b0;
      out_meth    <= '0;
      out_v       <= '0;
      heard_count <= '0;
    end else if (delay_fire) begin
      out_valid <= 1'b1;
      out_meth  <= head[W-1:DATA_W];
      out_v     <= head[DATA_W-1:0];
    end else if (respond_fire) begin
      out_valid   <= 1'b0;
      heard_count <= heard_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_queue.sv
module tb_echo_queue;
  import echo_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        say_ena = 1'b0;
  logic [31:0] say_meth = '0;
  logic [31:0] say_v = '0;
  logic        say_rdy;
  logic        h_ena;
  logic [31:0] h_meth, h_v;
  logic        h_rdy = 1'b0;
  logic [1:0]  ren = 2'b00;
  logic [1:0]  rrdy;
  logic [2:0]  occ;
  logic [15:0] hc;

  int n_tests = 0;
  int n_fail  = 0;
  echo_msg_t expq[$];
  echo_msg_t m;

  echo_queue dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .say__ENA              (say_ena),
    .say_meth              (say_meth),
    .say_v                 (say_v),
    .say__RDY              (say_rdy),
    .indication_heard__ENA (h_ena),
    .indication_heard_meth (h_meth),
    .indication_heard_v    (h_v),
    .indication_heard__RDY (h_rdy),
    .rule_enable           (ren),
    .rule_ready            (rrdy),
    .occupancy             (occ),
    .heard_count           (hc)
  );

  always #5 CLK = ~CLK;

  task automatic adv();
    @(posedge CLK); #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int got, sent, rcv;
    logic [2:0] occ_exp [6];
    occ_exp = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    adv(); adv();
    smp();
    chk("rst_say_rdy", say_rdy, 1'b1);
    chk("rst_rule_ready", rrdy, 2'b00);
    chk("rst_occ", occ, 3'd0);
    chk("rst_hc", hc, 16'd0);
    chk("rst_meth", h_meth, 32'd0);
    chk("rst_v", h_v, 32'd0);
    chk("rst_ena", h_ena, 1'b0);
    adv();
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      n_tests++;
      if (h_ena !== 1'b0) begin n_fail++; $error("FAIL idle_ena observed=%0h", h_ena); end
      adv();
    end

    ren = 2'b11; h_rdy = 1'b1;
    say_ena = 1'b1; say_meth = 32'd5; say_v = 32'hDEADBEEF;
    smp();
    chk("single_c0_say_rdy", say_rdy, 1'b1);
    chk("single_c0_rule_ready", rrdy, 2'b00);
    adv();
    say_ena = 1'b0;
    smp();
    chk("single_c1_rule_ready", rrdy, 2'b01);
    chk("single_c1_occ", occ, 3'd1);
    chk("single_c1_ena", h_ena, 1'b0);
    adv();
    smp();
    chk("single_c2_ena", h_ena, 1'b1);
    chk("single_c2_meth", h_meth, 32'd5);
    chk("single_c2_v", h_v, 32'hDEADBEEF);
    chk("single_c2_rule_ready", rrdy, 2'b10);
    adv();
    smp();
    chk("single_c3_hc", hc, 16'd1);
    chk("single_c3_ena", h_ena, 1'b0);
    chk("single_c3_occ", occ, 3'd0);
    adv();

    h_rdy = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      say_ena = 1'b1; say_v = 32'(v); say_meth = 32'(v + 100);
      smp();
      n_tests++;
      if (say_rdy !== 1'(v <= 5)) begin n_fail++; $error("FAIL fill_say_rdy observed=%0h", say_rdy); end
      n_tests++;
      if (occ !== occ_exp[v-1]) begin n_fail++; $error("FAIL fill_occ observed=%0h expected=%0h", occ, occ_exp[v-1]); end
      adv();
    end
    say_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      n_tests++;
      if (occ !== 3'd4) begin n_fail++; $error("FAIL stall_occ observed=%0h", occ); end
      n_tests++;
      if (say_rdy !== 1'b0) begin n_fail++; $error("FAIL stall_say_rdy observed=%0h", say_rdy); end
      n_tests++;
      if (h_ena !== 1'b0) begin n_fail++; $error("FAIL stall_ena observed=%0h", h_ena); end
      n_tests++;
      if (h_v !== 32'd1) begin n_fail++; $error("FAIL stall_v observed=%0h", h_v); end
      n_tests++;
      if (h_meth !== 32'd101) begin n_fail++; $error("FAIL stall_meth observed=%0h", h_meth); end
      adv();
    end
    h_rdy = 1'b1; ren = 2'b10;
    smp();
    chk("deliver1_ena", h_ena, 1'b1);
    chk("deliver1_v", h_v, 32'd1);
    adv();
    h_rdy = 1'b0; ren = 2'b01;
    say_ena = 1'b1; say_v = 32'd7; say_meth = 32'd107;
    smp();
    chk("full_say_rdy", say_rdy, 1'b0);
    chk("full_rule_ready", rrdy, 2'b01);
    chk("full_occ", occ, 3'd4);
    adv();
    smp();
    chk("after_deq_occ", occ, 3'd3);
    chk("after_deq_say_rdy", say_rdy, 1'b1);
    chk("after_deq_out_v", h_v, 32'd2);
    chk("after_deq_rule_ready", rrdy, 2'b00);
    adv();
    say_ena = 1'b0;
    smp();
    chk("refill_occ", occ, 3'd4);
    adv();

    foreach (occ_exp[i]) if (i >= 1 && i <= 4) begin
      m.meth = 32'(i + 101); m.v = 32'(i + 1); expq.push_back(m);
    end
    m.meth = 32'd107; m.v = 32'd7; expq.push_back(m);
    ren = 2'b11; h_rdy = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      smp();
      if (h_ena) begin
        m = expq.pop_front();
        n_tests++;
        if (h_v !== m.v) begin n_fail++; $error("FAIL drain_v observed=%0h expected=%0h", h_v, m.v); end
        n_tests++;
        if (h_meth !== m.meth) begin n_fail++; $error("FAIL drain_meth observed=%0h expected=%0h", h_meth, m.meth); end
        got++;
      end
      adv();
    end
    chk("drain_count", got, 5);
    smp();
    chk("drain_hc", hc, 16'd7);
    chk("drain_occ", occ, 3'd0);
    adv();

    h_rdy = 1'b0; ren = 2'b11;
    for (int i = 0; i < 4; i++) begin
      say_ena = 1'b1; say_v = 32'(32'hA0 + i); say_meth = 32'(i); adv();
    end
    say_ena = 1'b0; ren = 2'b00; h_rdy = 1'b1;
    smp();
    chk("pre_rst_occ", occ, 3'd3);
    chk("pre_rst_rule_ready", rrdy, 2'b10);
    adv();
    nRST = 1'b0; ren = 2'b11;
    smp();
    chk("rst_cycle_ena", h_ena, 1'b0);
    adv();
    smp();
    chk("post_rst_occ", occ, 3'd0);
    chk("post_rst_rule_ready", rrdy, 2'b00);
    chk("post_rst_hc", hc, 16'd0);
    chk("post_rst_ena", h_ena, 1'b0);
    chk("post_rst_v", h_v, 32'd0);
    adv();
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      n_tests++;
      if (h_ena !== 1'b0) begin n_fail++; $error("FAIL post_rst_no_stale observed=%0h", h_ena); end
      n_tests++;
      if (occ !== 3'd0) begin n_fail++; $error("FAIL post_rst_idle_occ observed=%0h", occ); end
      adv();
    end

    ren = 2'b11; sent = 0; rcv = 0;
    for (int c = 0; c < 400 && rcv < 20; c++) begin
      say_ena = (sent < 20); say_v = 32'(sent); say_meth = 32'(sent);
      h_rdy = 1'($urandom_range(0, 1));
      smp();
      if (h_ena) begin
        n_tests++;
        if (h_v !== 32'(rcv)) begin n_fail++; $error("FAIL wrap_v observed=%0h expected=%0h", h_v, rcv); end
        rcv++;
      end
      if (say_ena && say_rdy) sent++;
      adv();
    end
    say_ena = 1'b0;
    chk("wrap_rcv", rcv, 20);
    smp();
    chk("wrap_hc", hc, 16'd20);
    chk("wrap_occ", occ, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
